// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: bus-mapped compressor sequencer with stepped ramp, min-on/min-off timing and emergency stop
module comp_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0020,
  parameter logic [31:0] STEP_CYCLES    = 32'd25_000_000,
  parameter logic [31:0] MIN_OFF_CYCLES = 32'd1_500_000_000,
  parameter logic [31:0] MIN_ON_CYCLES  = 32'd1_500_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_rdata,
  input  logic        estop,
  output logic [3:0]  comp_drive
);
  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2, LOCKOUT = 2'd3} state_t;
  state_t      state;
  logic [3:0]  target;
  logic [3:0]  eff_target;
  logic        enable;
  logic        fault;
  logic        on_met;
  logic        sel_t;
  logic        sel_s;
  logic        sel_c;
  logic        step_due;
  logic        step_ok;
  logic [31:0] step_cnt;
  logic [31:0] on_cnt;
  logic [31:0] off_cnt;
  logic        unused_bits;
  assign unused_bits = ^{iomem_wdata[31:4], iomem_wstrb[3:1]};
  assign sel_t       = iomem_valid && iomem_addr == BASE_ADDR;
  assign sel_s       = iomem_valid && iomem_addr == BASE_ADDR + 32'h4;
  assign sel_c       = iomem_valid && iomem_addr == BASE_ADDR + 32'h8;
  assign iomem_ready = sel_t || sel_s || sel_c;
  assign eff_target  = (enable && !fault) ? target : 4'd0;
  assign on_met      = on_cnt >= MIN_ON_CYCLES;
  assign step_due    = step_cnt >= STEP_CYCLES - 32'd1;
  // the final 1->0 step must wait for the minimum on-time
  assign step_ok     = on_met || !(comp_drive == 4'd1 && eff_target == 4'd0);
  // read mux: only read cycles to a mapped register return data
  always_comb begin
    iomem_rdata = 32'd0;
    if (iomem_wstrb == 4'd0)
      iomem_rdata = sel_t ? {28'd0, target} :
                    sel_s ? {23'd0, fault, on_met, 1'b0, state, comp_drive} :
                    sel_c ? {31'd0, enable} : 32'd0;
  end
  // register writes, on-time counter and the sequencing FSM; estop overrides everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= LOCKOUT;
      comp_drive <= 4'd0;
      target     <= 4'd0;
      enable     <= 1'b0;
      fault      <= 1'b0;
      step_cnt   <= 32'd0;
      on_cnt     <= 32'd0;
      off_cnt    <= 32'd0;
    end else begin
      if (sel_t && iomem_wstrb[0]) target <= iomem_wdata[3:0];
      if (sel_c && iomem_wstrb[0]) enable <= iomem_wdata[0];
      if (sel_c && iomem_wstrb[0] && iomem_wdata[1] && !estop) fault <= 1'b0;
      if (comp_drive != 4'd0 && on_cnt != 32'hFFFF_FFFF) on_cnt <= on_cnt + 32'd1;
      if (estop) begin
        fault      <= 1'b1;
        comp_drive <= 4'd0;
        state      <= LOCKOUT;
        off_cnt    <= 32'd0;
      end else begin
        case (state)
          IDLE: if (eff_target != 4'd0) begin
            state    <= RAMP;
            step_cnt <= 32'd0;
          end
          RAMP: if (comp_drive == eff_target) begin
            state   <= (eff_target == 4'd0) ? LOCKOUT : RUN;
            off_cnt <= 32'd0;
          end else if (step_due && step_ok) begin
            comp_drive <= (eff_target > comp_drive) ? comp_drive + 4'd1 : comp_drive - 4'd1;
            step_cnt   <= 32'd0;
            if (comp_drive == 4'd0) on_cnt <= 32'd0;
          end else if (!step_due) begin
            step_cnt <= step_cnt + 32'd1;
          end
          RUN: if (eff_target != comp_drive) begin
            state    <= RAMP;
            step_cnt <= 32'd0;
          end
          LOCKOUT: if (off_cnt >= MIN_OFF_CYCLES - 32'd1) state <= IDLE;
                   else off_cnt <= off_cnt + 32'd1;
          default: state <= LOCKOUT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl: scoreboard bench with a timestamp-based reference model for comp_seq_ctrl
module tb_comp_seq_ctrl;
  localparam logic [31:0] BASE = 32'h0300_0020;
  localparam int STEP = 4;
  localparam int MOFF = 10;
  localparam int MON  = 20;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_rdata;
  logic        estop = 1'b0;
  logic [3:0]  comp_drive;
  int total = 0;
  int bad = 0;
  bit run = 0;
  logic [3:0]  drv_q[$];
  logic [32:0] acc_q[$];
  logic [32:0] mon_a;
  logic [31:0] bad_addr [4] = '{BASE + 32'hC, BASE + 32'h2, BASE - 32'h4, 32'h0};
  // reference model: levels plus the times at which ramp steps, on-time and lockout started
  logic [3:0] m_target, m_drive;
  logic       m_en, m_fault;
  logic [1:0] m_mode;
  longint     now = 0, t_anchor, t_on, t_stop, t_lock;

  comp_seq_ctrl #(
    .BASE_ADDR(BASE), .STEP_CYCLES(32'd4), .MIN_OFF_CYCLES(32'd10), .MIN_ON_CYCLES(32'd20)
  ) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb),
    .iomem_rdata(iomem_rdata), .estop(estop), .comp_drive(comp_drive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not reached at %0t", name, $time);
  endtask

  function automatic longint on_cnt_m();
    return (m_drive != 4'd0 ? now : t_stop) - t_on;
  endfunction

  function automatic logic [31:0] m_status();
    return {23'd0, m_fault, on_cnt_m() >= MON, 1'b0, m_mode, m_drive};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return a == BASE ? {28'd0, m_target} : a == BASE + 32'h4 ? m_status() : {31'd0, m_en};
  endfunction

  function automatic logic is_reg(input logic [31:0] a);
    return a == BASE || a == BASE + 32'h4 || a == BASE + 32'h8;
  endfunction

  task automatic model_reset();
    m_target = 0; m_drive = 0; m_en = 0; m_fault = 0; m_mode = 2'd3;
    t_anchor = now; t_on = now; t_stop = now; t_lock = now;
  endtask

  task automatic model_edge(input logic es, input logic v, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    longint     t;
    logic [3:0] eff;
    logic       met;
    logic [3:0] nd;
    t   = now + 1;
    eff = (m_en && !m_fault) ? m_target : 4'd0;
    met = on_cnt_m() >= MON;
    nd  = m_drive;
    if (v && s[0] && a == BASE) m_target = d[3:0];
    if (v && s[0] && a == BASE + 32'h8) begin
      m_en = d[0];
      if (d[1] && !es) m_fault = 0;
    end
    if (es) begin
      m_fault = 1; nd = 0; m_mode = 2'd3; t_lock = t;
    end else begin
      case (m_mode)
        2'd0: if (eff != 0) begin m_mode = 2'd1; t_anchor = t; end
        2'd1: if (m_drive == eff) begin
                m_mode = (eff == 0) ? 2'd3 : 2'd2; t_lock = t;
              end else if (t - t_anchor >= STEP && (eff != 0 || m_drive != 1 || met)) begin
                nd = eff > m_drive ? m_drive + 4'd1 : m_drive - 4'd1; t_anchor = t;
              end
        2'd2: if (eff != m_drive) begin m_mode = 2'd1; t_anchor = t; end
        default: if (t - t_lock >= MOFF) m_mode = 2'd0;
      endcase
    end
    if (m_drive == 0 && nd != 0) t_on = t;
    if (m_drive != 0 && nd == 0) t_stop = t;
    m_drive = nd;
    now = t;
  endtask

  // one bus cycle: drive inputs, queue the expected response, advance the model over the edge
  task automatic cyc(input logic es, input logic v, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    estop = es; iomem_valid = v; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    drv_q.push_back(m_drive);
    if (v && is_reg(a)) acc_q.push_back({s == 4'd0, m_read(a)});
    model_edge(es, v, a, d, s);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, a, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 4'hF);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("async_reset_drive", {28'd0, comp_drive}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      now++;
      #1;
      chk("reset_hold_drive", {28'd0, comp_drive}, 32'd0);
    end
    resetn = 1'b1;
    model_reset();
  endtask

  // monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (run && resetn) begin
      if (drv_q.size() == 0) miss("drive_queue_underrun");
      else chk("comp_drive", {28'd0, comp_drive}, {28'd0, drv_q.pop_front()});
      if (iomem_ready) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ready: unexpected ack for addr %h at %0t", iomem_addr, $time);
        end else begin
          mon_a = acc_q.pop_front();
          if (mon_a[32]) chk("rdata", iomem_rdata, mon_a[31:0]);
        end
      end else begin
        chk("rdata_unselected", iomem_rdata, 32'd0);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    run = 1;
    repeat (12) rd(BASE + 32'h4);
    wr(BASE, 32'd3);
    wr(BASE + 32'h8, 32'd1);
    n = 0;
    while (n < 40 && !(m_drive == 3 && on_cnt_m() == 8)) begin rd(BASE + 32'h4); n++; end
    if (n == 40) miss("reach_level3");
    wr(BASE, 32'd0);
    repeat (60) rd(BASE + 32'h4);
    wr(BASE, 32'd3);
    n = 0;
    while (n < 40 && m_drive != 2) begin rd(BASE + 32'h4); n++; end
    if (n == 40) miss("reach_level2");
    wr(BASE, 32'hFFFF_FFF9);
    repeat (40) rd(BASE + 32'h4);
    wr(BASE, 32'd5);
    n = 0;
    while (n < 60 && !(m_mode == 2 && m_drive == 5)) begin rd(BASE + 32'h4); n++; end
    if (n == 60) miss("reach_run5");
    cyc(1'b1, 1'b1, BASE + 32'h8, 32'd3, 4'h1);
    repeat (3) rd(BASE + 32'h4);
    wr(BASE + 32'h8, 32'd3);
    n = 0;
    while (n < 80 && !(m_mode == 1 && m_drive == 2)) begin rd(BASE + 32'h4); n++; end
    if (n == 80) miss("reach_ramp2");
    chk("pre_reset_drive", {28'd0, comp_drive}, 32'd2);
    do_reset();
    rd(BASE);
    rd(BASE + 32'h8);
    repeat (12) rd(BASE + 32'h4);
    wr(BASE + 32'h8, 32'd1);
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [31:0] d;
      logic [3:0]  s;
      logic        es;
      r  = $urandom_range(0, 99);
      d  = $urandom;
      s  = 4'($urandom);
      es = ($urandom_range(0, 149) == 0);
      if (r < 5) begin
        s[0] = 1'b1; cyc(1'b0, 1'b1, BASE, d, s);
      end else if (r < 8) begin
        s[0] = 1'b1; d[0] = ($urandom_range(0, 3) != 0); cyc(1'b0, 1'b1, BASE + 32'h8, d, s);
      end else if (r < 11) begin
        s[0] = 1'b0; cyc(es, 1'b1, BASE + 32'(4 * $urandom_range(0, 2)), d, s);
      end else if (r < 13) begin
        s[0] = 1'b1; cyc(1'b0, 1'b1, BASE + 32'h4, d, s);
      end else if (r < 17) begin
        s[0] = 1'b0; cyc(es, 1'b1, bad_addr[$urandom_range(0, 3)], d, s);
      end else if (r < 22) begin
        cyc(es, 1'b0, BASE, d, s);
      end else begin
        cyc(es, 1'b1, BASE + 32'(4 * $urandom_range(0, 2)), 32'd0, 4'd0);
      end
    end
    run = 0;
    chk("access_queue_left", 32'(acc_q.size()), 32'd0);
    chk("drive_queue_left", 32'(drv_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/comp_seq_ctrl.md
COMP_SEQ_CTRL -- requirements
Module: comp_seq_ctrl

Interface
REQ-001 The block SHALL take the following parameters (name, default, meaning), one per line:
- BASE_ADDR, 32'h0300_0020, word-aligned register base.
- STEP_CYCLES, 25_000_000, clk cycles between drive steps; must be at least 1.
- MIN_OFF_CYCLES, 1_500_000_000, minimum time with the drive at 0 before a restart.
- MIN_ON_CYCLES, 1_500_000_000, minimum time with the drive non-zero before a stop.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- resetn, in, 1, reset: asynchronous, active-low.
- iomem_valid, in, 1, bus request.
- iomem_ready, out, 1, bus acknowledge.
- iomem_addr, in, 32, byte address.
- iomem_wdata, in, 32, write data.
- iomem_wstrb, in, 4, byte write strobes; 0 = read.
- iomem_rdata, out, 32, read data.
- estop, in, 1, synchronous emergency-stop request.
- comp_drive, out, 4, compressor level 0..15.
REQ-003 The register map SHALL be:
- +0x0 TARGET: RW, bits[3:0].
- +0x4 STATUS: RO.
- +0x8 CTRL: bit0 enable RW; bit1 fault-clear, write-1, reads 0.

Function
REQ-004 iomem_ready SHALL be combinational: high only in a cycle where iomem_valid is high and iomem_addr equals BASE_ADDR+0x0, +0x4 or +0x8; there are no wait states.
REQ-005 Writes SHALL take effect at the clk edge ending the ready cycle, and only when iomem_wstrb[0] is 1; wdata bits above the defined fields SHALL be ignored; a write to STATUS SHALL have no effect.
REQ-006 iomem_rdata SHALL be combinational:
- TARGET reads {28'b0, target}.
- STATUS reads {23'b0, fault, on_met, state[2:0], comp_drive}.
- CTRL reads {31'b0, enable}.
- All other cycles read 0.
REQ-007 eff_target SHALL equal target when enable is 1 and fault is 0, and SHALL be 0 otherwise.
REQ-008 The state encodings SHALL be IDLE=0, RAMP=1, RUN=2, LOCKOUT=3; comp_drive SHALL be a register.
REQ-009 In IDLE, comp_drive is 0; when eff_target != 0 the FSM SHALL go to RAMP and clear step_cnt.
REQ-010 In RAMP, step_cnt SHALL increment each cycle; at STEP_CYCLES-1 it SHALL clear and comp_drive SHALL move one step toward eff_target, so the first step occurs STEP_CYCLES cycles after RAMP entry.
REQ-011 A step from 1 to 0 SHALL be permitted only when on_met=1. Otherwise step_cnt SHALL hold at its terminal count, and the step SHALL occur in the first cycle on_met becomes 1.
REQ-012 When comp_drive equals eff_target in RAMP, the FSM SHALL enter LOCKOUT if the level is 0, and RUN otherwise.
REQ-013 In RUN, when eff_target != comp_drive the FSM SHALL enter RAMP with step_cnt cleared.
REQ-014 A TARGET or enable change during RAMP SHALL be used at the next step decision, with no step_cnt restart; the direction SHALL reverse freely.
REQ-015 on_cnt (32-bit) SHALL clear on every 0->1 comp_drive transition and count up, saturating, while comp_drive != 0; on_met = (on_cnt >= MIN_ON_CYCLES).
REQ-016 LOCKOUT:
- On entry, off_cnt SHALL clear; comp_drive stays 0.
- When off_cnt reaches MIN_OFF_CYCLES-1, the FSM SHALL go to IDLE.
- TARGET/CTRL writes during LOCKOUT SHALL be stored but SHALL NOT shorten it.
REQ-017 estop=1 in any state SHALL, at the next edge:
- set fault;
- force comp_drive to 0, bypassing the step timing and min-on;
- enter LOCKOUT, restarting off_cnt, or continue LOCKOUT if already there.
estop has priority over all bus writes in the same cycle.
REQ-018 A fault-clear write SHALL clear fault only if estop=0 in that cycle; otherwise fault SHALL remain set.
REQ-019 All counters SHALL be 32-bit and SHALL never wrap.

Reset
REQ-020 Asserting resetn low SHALL immediately clear comp_drive, target, enable, fault, step_cnt, on_cnt and off_cnt, and SHALL set the state to LOCKOUT. This applies at any point, including mid-ramp.
REQ-021 After reset is released, a full MIN_OFF_CYCLES lockout SHALL elapse before any start.

Verification (STEP_CYCLES=4, MIN_OFF_CYCLES=10, MIN_ON_CYCLES=20)
REQ-022 Release reset -> STATUS = 0x030 for 10 cycles, then 0x000 (IDLE).
REQ-023 In IDLE, write TARGET=3 then CTRL=1 -> comp_drive = 1, 2, 3 at 4, 8, 12 cycles after RAMP entry; then STATUS = 0x023.
REQ-024 At level 3 with on_cnt=8, write TARGET=0 -> drive steps to 2, then 1, holds at 1 until on_cnt=20, then goes to 0 -> LOCKOUT for 10 cycles -> IDLE.
REQ-025 Ramp toward 3, at level 2 write TARGET=9 -> drive continues 3..9 at 4-cycle spacing with no restart gap, then RUN.
REQ-026 estop pulse at RUN level 5 -> comp_drive=0 next edge, STATUS=0x130. A fault-clear write while estop=1 is ignored. Clear after estop=0, then lockout ends -> IDLE -> ramps to TARGET again.
REQ-027 resetn low at ramp level 2 -> comp_drive=0 without a clk edge; TARGET/CTRL read 0 after release.
